// File: rtl/sel_ctrl_pkg.sv
// Shared definitions for the select-debounce control slice: FSM state
// encoding, default timing constants and the debug view of the FSM.
package sel_ctrl_pkg;

  // Switchover FSM states. The encoding is fixed so that waveform viewers
  // and external checkers can decode the debug state directly.
  typedef enum logic [1:0] {
    SEL_A    = 2'd0,
    GUARD_AB = 2'd1,
    SEL_B    = 2'd2,
    GUARD_BA = 2'd3
  } sel_state_e;

  // Default number of synchronised cycles a request must persist before
  // its debounced value flips.
  localparam int DEBOUNCE_DEF = 4;

  // Default number of cycles spent in a guard state before sel moves.
  localparam int GUARD_DEF = 2;

  // Default counter width; 2**CNT_W must exceed max(DEBOUNCE, GUARD).
  localparam int CNT_W_DEF = 3;

endpackage

// File: rtl/sel_debounce.sv
// Two-flop synchroniser followed by a persistence counter. The output only
// follows the input once the synchronised value has differed from the
// current stable value on DEBOUNCE consecutive rising edges.
module sel_debounce
  import sel_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic areset,
  input  logic din,
  output logic dout
);

  // Counter value on which the last differing edge commits the new value.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Two-stage synchroniser for the asynchronous raw request.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  // Persistence counter: any edge agreeing with the stable value restarts
  // the count, so short glitches never reach the output.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync_q2 != stable) begin
      if (cnt == DB_LAST) begin
        stable <= sync_q2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign dout = stable;

endmodule

// File: rtl/sel_debounce_ctrl.sv
// Upstream control for the two-select 2:1 mux. Both raw requests are
// synchronised and debounced, then a guarded FSM moves sel_b1/sel_b2
// together between 00 and 11 so the mux never sees a half-selected code.
module sel_debounce_ctrl
  import sel_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int GUARD    = GUARD_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic areset,
  input  logic req_b1,
  input  logic req_b2,
  output logic sel_b1,
  output logic sel_b2,
  output logic switching,
  output logic db_b1,
  output logic db_b2
);

  // Guard counter load value; a guard state lasts GUARD cycles because the
  // exit happens on the edge that finds the counter at zero.
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);

  // Current FSM state; kept as a named typed signal so checkers and
  // waveform viewers can bind to it directly.
  sel_state_e       state;
  logic [CNT_W-1:0] gcnt;
  logic             want_b;

  sel_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .CNT_W    (CNT_W)
  ) u_db_b1 (
    .clk    (clk),
    .areset (areset),
    .din    (req_b1),
    .dout   (db_b1)
  );

  sel_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .CNT_W    (CNT_W)
  ) u_db_b2 (
    .clk    (clk),
    .areset (areset),
    .din    (req_b2),
    .dout   (db_b2)
  );

  // Path b is wanted only when both debounced requests agree on it.
  assign want_b = db_b1 & db_b2;

  // Switchover FSM with guard counter; sel/switching are registered here
  // alongside the state so both selects always move on the same edge.
  // An abort (want_b changing back during a guard) wins over the count.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= SEL_A;
      gcnt      <= '0;
      sel_b1    <= 1'b0;
      sel_b2    <= 1'b0;
      switching <= 1'b0;
    end else begin
      case (state)
        SEL_A: begin
          if (want_b) begin
            state     <= GUARD_AB;
            gcnt      <= GUARD_LAST;
            switching <= 1'b1;
          end
        end
        GUARD_AB: begin
          if (!want_b) begin
            state     <= SEL_A;
            gcnt      <= '0;
            switching <= 1'b0;
          end else if (gcnt == '0) begin
            state     <= SEL_B;
            sel_b1    <= 1'b1;
            sel_b2    <= 1'b1;
            switching <= 1'b0;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        SEL_B: begin
          if (!want_b) begin
            state     <= GUARD_BA;
            gcnt      <= GUARD_LAST;
            switching <= 1'b1;
          end
        end
        GUARD_BA: begin
          if (want_b) begin
            state     <= SEL_B;
            gcnt      <= '0;
            switching <= 1'b0;
          end else if (gcnt == '0) begin
            state     <= SEL_A;
            sel_b1    <= 1'b0;
            sel_b2    <= 1'b0;
            switching <= 1'b0;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        default: begin
          state     <= SEL_A;
          gcnt      <= '0;
          sel_b1    <= 1'b0;
          sel_b2    <= 1'b0;
          switching <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sel_debounce_ctrl.sv
// Bench for sel_debounce_ctrl: directed scenarios followed by randomized
// request patterns, all compared against a behavioural reference model.
module tb_sel_debounce_ctrl;

  localparam int DEBOUNCE = 4;
  localparam int GUARD    = 2;
  localparam int CNT_W    = 3;

  typedef bit bitq_t[$];

  // Clock and reset
  logic clk = 1'b0;
  logic areset;
  logic req_b1;
  logic req_b2;
  logic sel_b1;
  logic sel_b2;
  logic switching;
  logic db_b1;
  logic db_b2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sel_debounce_ctrl #(
    .DEBOUNCE (DEBOUNCE),
    .GUARD    (GUARD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .areset    (areset),
    .req_b1    (req_b1),
    .req_b2    (req_b2),
    .sel_b1    (sel_b1),
    .sel_b2    (sel_b2),
    .switching (switching),
    .db_b1     (db_b1),
    .db_b2     (db_b2)
  );

  // Reference model: raw samples travel through a 2-entry delay queue,
  // each channel keeps the list of synchronised values seen since its last
  // flip, and the selector is a phase (0 A, 1 to-B, 2 B, 3 to-A) with an
  // elapsed-cycle count.
  bitq_t m_raw0, m_raw1;
  bitq_t m_hist0, m_hist1;
  bit    m_db0, m_db1;
  int    m_phase;
  int    m_elapsed;

  function automatic void model_reset();
    m_raw0    = '{1'b0, 1'b0};
    m_raw1    = '{1'b0, 1'b0};
    m_hist0   = {};
    m_hist1   = {};
    m_db0     = 1'b0;
    m_db1     = 1'b0;
    m_phase   = 0;
    m_elapsed = 0;
  endfunction

  // True when the last DEBOUNCE synchronised values all disagree with stable.
  function automatic bit window_flips(bitq_t h, bit stable);
    if (h.size() < DEBOUNCE) return 1'b0;
    for (int k = h.size() - DEBOUNCE; k < h.size(); k++)
      if (h[k] == stable) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_edge(bit r1, bit r2);
    bit want;
    bit u0;
    bit u1;
    want = m_db0 & m_db1;
    case (m_phase)
      0: if (want) begin m_phase = 1; m_elapsed = 0; end
      1: begin
        if (!want) m_phase = 0;
        else begin
          m_elapsed++;
          if (m_elapsed == GUARD) m_phase = 2;
        end
      end
      2: if (!want) begin m_phase = 3; m_elapsed = 0; end
      default: begin
        if (want) m_phase = 2;
        else begin
          m_elapsed++;
          if (m_elapsed == GUARD) m_phase = 0;
        end
      end
    endcase
    m_raw0.push_back(r1);
    m_raw1.push_back(r2);
    u0 = m_raw0.pop_front();
    u1 = m_raw1.pop_front();
    if (u0 != m_db0) m_hist0.push_back(u0); else m_hist0 = {};
    if (u1 != m_db1) m_hist1.push_back(u1); else m_hist1 = {};
    if (window_flips(m_hist0, m_db0)) begin m_db0 = ~m_db0; m_hist0 = {}; end
    if (window_flips(m_hist1, m_db1)) begin m_db1 = ~m_db1; m_hist1 = {}; end
  endfunction

  // Scoreboard compare
  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_sel_b1"}, sel_b1, logic'(m_phase == 2 || m_phase == 3));
    check({tag, "_sel_b2"}, sel_b2, logic'(m_phase == 2 || m_phase == 3));
    check({tag, "_switching"}, switching, logic'(m_phase == 1 || m_phase == 3));
    check({tag, "_db_b1"}, db_b1, logic'(m_db0));
    check({tag, "_db_b2"}, db_b2, logic'(m_db1));
    check({tag, "_sel_pair"}, sel_b1, sel_b2);
  endtask

  // Driver: set requests at the falling edge, advance one rising edge,
  // then compare at the next falling edge.
  task automatic step(input logic r1, input logic r2);
    req_b1 = r1;
    req_b2 = r2;
    @(posedge clk);
    model_edge(r1, r2);
    @(negedge clk);
    check_all("step");
  endtask

  task automatic settle(input logic r1, input logic r2, input int n);
    for (int k = 0; k < n; k++) step(r1, r2);
  endtask

  // Reset pulse asserted between edges; outputs must clear at once.
  task automatic pulse_reset(input string tag);
    #2;
    areset = 1'b1;
    model_reset();
    #1;
    check({tag, "_sel_b1"}, sel_b1, 1'b0);
    check({tag, "_sel_b2"}, sel_b2, 1'b0);
    check({tag, "_switching"}, switching, 1'b0);
    check({tag, "_db_b1"}, db_b1, 1'b0);
    check({tag, "_db_b2"}, db_b2, 1'b0);
    @(negedge clk);
    areset = 1'b0;
    check_all({tag, "_after"});
  endtask

  initial begin
    logic r1;
    logic r2;
    int   len;

    areset = 1'b1;
    req_b1 = 1'b0;
    req_b2 = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_sel_b1", sel_b1, 1'b0);
    check("reset_sel_b2", sel_b2, 1'b0);
    check("reset_switching", switching, 1'b0);
    check("reset_db_b1", db_b1, 1'b0);
    check("reset_db_b2", db_b2, 1'b0);
    areset = 1'b0;
    settle(1'b0, 1'b0, 3);

    // Both requests rise together; edge 0 is the first sampling edge.
    for (int e = 0; e <= 8; e++) begin
      step(1'b1, 1'b1);
      check("rise_db_b1", db_b1, logic'(e >= 5));
      check("rise_db_b2", db_b2, logic'(e >= 5));
      check("rise_switching", switching, logic'(e == 6 || e == 7));
      check("rise_sel_b1", sel_b1, logic'(e >= 8));
      check("rise_sel_b2", sel_b2, logic'(e >= 8));
    end
    settle(1'b1, 1'b1, 2);

    // Release both from SEL_B; selects fall together after the guard.
    for (int e = 0; e <= 8; e++) begin
      step(1'b0, 1'b0);
      check("fall_db_b1", db_b1, logic'(e < 5));
      check("fall_switching", switching, logic'(e == 6 || e == 7));
      check("fall_sel_b1", sel_b1, logic'(e < 8));
      check("fall_sel_b2", sel_b2, logic'(e < 8));
    end
    settle(1'b0, 1'b0, 2);

    // Three-cycle glitch on req_b1 with req_b2 held high.
    settle(1'b0, 1'b1, 8);
    check("glitch_pre_db_b2", db_b2, 1'b1);
    for (int e = 0; e < 12; e++) begin
      step(logic'(e < 3), 1'b1);
      check("glitch_db_b1", db_b1, 1'b0);
      check("glitch_switching", switching, 1'b0);
      check("glitch_sel_b1", sel_b1, 1'b0);
    end

    // Only req_b1 held high: debounced, but the mux keeps path a.
    settle(1'b0, 1'b0, 8);
    for (int e = 0; e < 20; e++) begin
      step(1'b1, 1'b0);
      check("single_sel_b1", sel_b1, 1'b0);
      check("single_switching", switching, 1'b0);
    end
    check("single_db_b1", db_b1, 1'b1);
    check("single_db_b2", db_b2, 1'b0);

    // Abort: req_b2 debounces low while in GUARD_AB.
    settle(1'b0, 1'b1, 8);
    for (int e = 0; e <= 12; e++) begin
      step(1'b1, logic'(e < 2));
      check("abort_switching", switching, logic'(e == 6 || e == 7));
      check("abort_sel_b1", sel_b1, 1'b0);
      check("abort_sel_b2", sel_b2, 1'b0);
    end

    // Asynchronous reset in the middle of GUARD_AB.
    settle(1'b0, 1'b0, 8);
    settle(1'b1, 1'b1, 7);
    check("rst_pre_switching", switching, 1'b1);
    req_b1 = 1'b0;
    req_b2 = 1'b0;
    pulse_reset("rst_mid_guard");
    for (int e = 0; e < 4; e++) begin
      step(1'b0, 1'b0);
      check("rst_post_sel_b1", sel_b1, 1'b0);
      check("rst_post_switching", switching, 1'b0);
    end

    // Randomized request patterns held for random lengths.
    for (int blk = 0; blk < 60; blk++) begin
      r1  = logic'($urandom_range(0, 1));
      r2  = logic'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 24) == 0) pulse_reset("rand_reset");
      settle(r1, r2, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
